// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issue path: opcode map, instruction field
// positions and issue-controller state encoding.
package instr_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_AND  = 6'd2;
   localparam logic [5:0] OP_OR   = 6'd3;
   localparam logic [5:0] OP_SLL  = 6'd4;
   localparam logic [5:0] OP_SRL  = 6'd5;
   localparam logic [5:0] OP_SRA  = 6'd6;
   localparam logic [5:0] OP_SLT  = 6'd7;
   localparam logic [5:0] OP_SLTU = 6'd8;
   localparam logic [5:0] OP_NOR  = 6'd9;
   localparam logic [5:0] OP_XOR  = 6'd10;

   localparam int unsigned NUM_OPS = 11;

   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RS1_LSB = 21;
   localparam int unsigned RS2_LSB = 16;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned REGW    = 5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_READ   = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;

   // Opcodes are dense from zero, so legality is a single bound check.
   function automatic logic op_is_legal(input logic [31:0] op_ext, input int unsigned num_ops);
      return op_ext < num_ops;
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of a 32-bit instruction word into opcode and register fields,
// plus an opcode legality flag. Shared with the ALU control path.
module instr_field_decode #(
   parameter int unsigned OPW     = 6,
   parameter int unsigned NUM_OPS = 11
) (
   input  logic [31:0]    instr,
   output logic [OPW-1:0] opcode,
   output logic [4:0]     rs1,
   output logic [4:0]     rs2,
   output logic [4:0]     rd,
   output logic           opcode_legal
);
   import instr_pkg::*;

   logic unused_low_bits;

   assign opcode = instr[OP_LSB +: OPW];
   assign rs1    = instr[RS1_LSB +: REGW];
   assign rs2    = instr[RS2_LSB +: REGW];
   assign rd     = instr[RD_LSB +: REGW];

   assign opcode_legal = op_is_legal({{(32 - OPW){1'b0}}, opcode}, NUM_OPS);

   assign unused_low_bits = ^instr[10:0];

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue/sequencing controller in front of the 32x32 register file: accepts one
// instruction at a time, reads operands, launches the ALU and retires the result.
module instr_issue_ctrl #(
   parameter int unsigned OPW     = 6,
   parameter int unsigned NUM_OPS = 11,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNTW    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   output logic [4:0]      rf_addr1,
   output logic [4:0]      rf_addr2,
   output logic [4:0]      rf_addr3,
   output logic            rf_rd_en,
   output logic            rf_wr_en,
   output logic [OPW-1:0]  alu_opcode,
   output logic            alu_start,
   input  logic            alu_done,
   output logic            illegal_op,
   output logic            timeout_err,
   output logic [CNTW-1:0] retired_cnt
);
   import instr_pkg::*;

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [2:0]      state_q, state_d;
   logic [31:0]     instr_q;
   logic [TW-1:0]   exec_cnt_q, exec_cnt_d;
   logic            illegal_q, illegal_d;
   logic            timeout_q, timeout_d;
   logic [CNTW-1:0] retired_q, retired_d;

   logic [OPW-1:0]  opcode;
   logic [4:0]      rs1, rs2, rd;
   logic            opcode_legal;
   logic            accept;

   instr_field_decode #(
      .OPW     (OPW),
      .NUM_OPS (NUM_OPS)
   ) u_decode (
      .instr        (instr_q),
      .opcode       (opcode),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .opcode_legal (opcode_legal)
   );

   assign accept = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      exec_cnt_d = exec_cnt_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      retired_d  = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (opcode_legal) begin
               state_d = ST_READ;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_READ: begin
            exec_cnt_d = TW'(1);
            state_d    = ST_EXEC;
         end
         ST_EXEC: begin
            // A done on the final allowed cycle still wins over the abort.
            if (alu_done) begin
               state_d = ST_WB;
            end else if (exec_cnt_q == TW'(TIMEOUT)) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               exec_cnt_d = exec_cnt_q + TW'(1);
            end
         end
         ST_WB: begin
            retired_d = retired_q + CNTW'(1);
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         instr_q    <= '0;
         exec_cnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         exec_cnt_q <= exec_cnt_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         retired_q  <= retired_d;
         if (accept) instr_q <= instr;
      end
   end

   // Strobes decode straight from state so reset kills them without waiting for a clock.
   assign instr_ready = (state_q == ST_IDLE);
   assign rf_rd_en    = (state_q == ST_READ);
   assign alu_start   = (state_q == ST_READ);
   assign rf_wr_en    = (state_q == ST_WB) && (rd != 5'd0);

   assign rf_addr1    = rs1;
   assign rf_addr2    = rs2;
   assign rf_addr3    = rd;
   assign alu_opcode  = opcode;

   assign illegal_op  = illegal_q;
   assign timeout_err = timeout_q;
   assign retired_cnt = retired_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl; a second instance with a 2-bit retire counter
// shares the stimulus so counter wrap is reachable in a few instructions.
module tb_instr_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        alu_done = 1'b0;

   logic        instr_ready, rf_rd_en, rf_wr_en, alu_start, illegal_op, timeout_err;
   logic [4:0]  rf_addr1, rf_addr2, rf_addr3;
   logic [5:0]  alu_opcode;
   logic [15:0] retired_cnt;

   logic        unused_s_ready, unused_s_rd, unused_s_wr, unused_s_start, unused_s_ill, unused_s_to;
   logic [4:0]  unused_s_a1, unused_s_a2, unused_s_a3;
   logic [5:0]  unused_s_op;
   logic [1:0]  s_retired;

   int checks = 0;
   int errors = 0;
   logic wr_seen;

   always #5 clk = ~clk;

   instr_issue_ctrl dut (
      .clk (clk), .rst_n (rst_n), .instr (instr), .instr_valid (instr_valid),
      .instr_ready (instr_ready), .rf_addr1 (rf_addr1), .rf_addr2 (rf_addr2),
      .rf_addr3 (rf_addr3), .rf_rd_en (rf_rd_en), .rf_wr_en (rf_wr_en),
      .alu_opcode (alu_opcode), .alu_start (alu_start), .alu_done (alu_done),
      .illegal_op (illegal_op), .timeout_err (timeout_err), .retired_cnt (retired_cnt)
   );

   instr_issue_ctrl #(.CNTW (2)) u_small (
      .clk (clk), .rst_n (rst_n), .instr (instr), .instr_valid (instr_valid),
      .instr_ready (unused_s_ready), .rf_addr1 (unused_s_a1), .rf_addr2 (unused_s_a2),
      .rf_addr3 (unused_s_a3), .rf_rd_en (unused_s_rd), .rf_wr_en (unused_s_wr),
      .alu_opcode (unused_s_op), .alu_start (unused_s_start), .alu_done (alu_done),
      .illegal_op (unused_s_ill), .timeout_err (unused_s_to), .retired_cnt (s_retired)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [4:0] d);
      return {op, a, b, d, 11'h5a5};
   endfunction

   initial begin
      // Reset state
      #12;
      check("rst_ready", instr_ready, 1);
      check("rst_addr1", rf_addr1, 0);
      check("rst_addr3", rf_addr3, 0);
      check("rst_opcode", alu_opcode, 0);
      check("rst_strobes", {rf_rd_en, rf_wr_en, alu_start}, 0);
      check("rst_flags", {illegal_op, timeout_err}, 0);
      check("rst_retired", retired_cnt, 0);
      rst_n = 1'b1;
      step();

      // Legal issue, alu_done tied high
      alu_done = 1'b1;
      instr = mk(6'd0, 5'd1, 5'd2, 5'd3);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      check("leg_c1_ready", instr_ready, 0);
      check("leg_c1_addrs", {rf_addr1, rf_addr2, rf_addr3}, {5'd1, 5'd2, 5'd3});
      check("leg_c1_rd", {rf_rd_en, alu_start}, 0);
      step();
      check("leg_c2_rd_start", {rf_rd_en, alu_start}, 2'b11);
      check("leg_c2_opcode", alu_opcode, 0);
      step();
      check("leg_c3_quiet", {rf_rd_en, rf_wr_en, alu_start}, 0);
      step();
      check("leg_c4_wr", rf_wr_en, 1);
      check("leg_c4_addr3", rf_addr3, 3);
      check("leg_c4_retired", retired_cnt, 0);
      step();
      check("leg_c5_ready", instr_ready, 1);
      check("leg_c5_wr_off", rf_wr_en, 0);
      check("leg_c5_retired", retired_cnt, 1);

      // First illegal opcode: 11, just past the legal range
      instr = mk(6'd11, 5'd4, 5'd5, 5'd6);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      check("ill11_c1_flag", illegal_op, 0);
      check("ill11_c1_ready", instr_ready, 0);
      step();
      check("ill11_c2_flag", illegal_op, 1);
      check("ill11_c2_ready", instr_ready, 1);
      check("ill11_c2_strobes", {rf_rd_en, rf_wr_en, alu_start}, 0);

      // Illegal opcode 63
      instr = mk(6'd63, 5'd7, 5'd8, 5'd9);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      check("ill63_c1_strobes", {rf_rd_en, rf_wr_en, alu_start}, 0);
      step();
      check("ill63_c2_ready", instr_ready, 1);
      check("ill63_c2_strobes", {rf_rd_en, rf_wr_en, alu_start}, 0);
      check("ill63_retired", retired_cnt, 1);
      step();
      check("ill63_c3_idle", {instr_ready, rf_rd_en, alu_start}, 3'b100);

      // rd = 0 still retires but never writes
      instr = mk(6'd2, 5'd7, 5'd8, 5'd0);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      step();
      step();
      check("rd0_wb_nowr", rf_wr_en, 0);
      check("rd0_wb_busy", instr_ready, 0);
      step();
      check("rd0_retired", retired_cnt, 2);

      // Timeout: alu_done never arrives
      alu_done = 1'b0;
      instr = mk(6'd1, 5'd9, 5'd10, 5'd11);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      wr_seen = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         wr_seen |= rf_wr_en;
      end
      check("to_exec16_busy", instr_ready, 0);
      check("to_exec16_noerr", timeout_err, 0);
      step();
      check("to_err_set", timeout_err, 1);
      check("to_ready", instr_ready, 1);
      check("to_no_write", wr_seen | rf_wr_en, 0);
      check("to_retired", retired_cnt, 2);

      // alu_done on exactly the 16th EXEC cycle succeeds
      instr = mk(6'd4, 5'd12, 5'd13, 5'd14);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      for (int k = 1; k <= 16; k++) step();
      check("d16_still_busy", instr_ready, 0);
      alu_done = 1'b1;
      step();
      check("d16_wr", rf_wr_en, 1);
      check("d16_addr3", rf_addr3, 14);
      step();
      check("d16_retired", retired_cnt, 3);
      check("d16_small_pre_wrap", s_retired, 3);

      // Back-to-back with instr_valid held high; instr changes while busy
      instr = mk(6'd10, 5'd15, 5'd16, 5'd17);
      instr_valid = 1'b1;
      step();
      instr = mk(6'd3, 5'd18, 5'd19, 5'd20);
      check("b2b_a_busy", instr_ready, 0);
      check("b2b_a_addr1", rf_addr1, 15);
      step();
      check("b2b_a_held_addr", {rf_addr1, rf_addr2, rf_addr3}, {5'd15, 5'd16, 5'd17});
      check("b2b_a_opcode", alu_opcode, 10);
      check("b2b_a_rd", rf_rd_en, 1);
      step();
      step();
      check("b2b_a_wr", rf_wr_en, 1);
      step();
      check("b2b_a_idle", instr_ready, 1);
      check("b2b_small_wrap", s_retired, 0);
      check("b2b_a_retired", retired_cnt, 4);
      step();
      check("b2b_b_accept", instr_ready, 0);
      check("b2b_b_addr1", rf_addr1, 18);
      instr = mk(6'd5, 5'd21, 5'd22, 5'd23);
      step();
      step();
      step();
      check("b2b_b_wr", rf_wr_en, 1);
      step();
      check("b2b_b_idle", instr_ready, 1);
      step();
      instr_valid = 1'b0;
      check("b2b_c_addr3", rf_addr3, 23);
      step();
      step();
      step();
      step();
      check("b2b_retired", retired_cnt, 6);
      check("b2b_small", s_retired, 2);

      // Reset during EXEC
      alu_done = 1'b0;
      instr = mk(6'd0, 5'd1, 5'd2, 5'd5);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      step();
      check("rx_in_exec", instr_ready, 0);
      rst_n = 1'b0;
      #1;
      check("rx_strobes", {rf_rd_en, rf_wr_en, alu_start}, 0);
      check("rx_ready", instr_ready, 1);
      check("rx_addr3", rf_addr3, 0);
      check("rx_cnt_flags", {retired_cnt, illegal_op, timeout_err}, 0);
      alu_done = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      wr_seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         wr_seen |= rf_wr_en;
      end
      check("rx_no_write", wr_seen, 0);
      check("rx_retired", retired_cnt, 0);
      check("rx_idle", instr_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
